rgb_fade_sequencer: RTL and testbench

- Autonomous colour scheduler for the RGB PWM datapath.
- Steps through a fixed 7-entry rainbow palette and crossfades each channel linearly toward the next entry.
- Drives the three 8-bit duty-cycle inputs of the per-channel pwm instances, replacing direct button-indexed colour selection.
- Has manual skip and direction control, and a run/pause control.

---
 rtl/rgb_fade_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_rgb_fade_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_fade_sequencer.sv
// rgb_fade_sequencer: steps through a 7-entry rainbow palette, resting on
// each colour for HOLD_TICKS step_tick strobes and then crossfading every
// channel linearly toward the next colour by STEP per strobe.
// Optional feature macro: RGB_SEQ_DIM_EN adds a 2-bit 'dim' input and a
// registered output stage that right-shifts the duties by 'dim'.
module rgb_fade_sequencer #(
  parameter int HOLD_TICKS = 100,
  parameter int STEP       = 1
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       step_tick,
  input  logic       run,
  input  logic       dir,
  input  logic       skip,
`ifdef RGB_SEQ_DIM_EN
  input  logic [1:0] dim,
`endif
  output logic [7:0] duty_r,
  output logic [7:0] duty_g,
  output logic [7:0] duty_b,
  output logic [2:0] color_idx,
  output logic       busy,
  output logic       wrap
);

  typedef enum logic [1:0] {IDLE, HOLD, FADE} state_t;

  localparam int             HCW       = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_TICKS - 1);
  localparam logic [7:0]     STEP8     = 8'(STEP);

  function automatic logic [23:0] palette(input logic [2:0] idx);
    case (idx)
      3'd0:    palette = 24'h7F0000;
      3'd1:    palette = 24'h7F5200;
      3'd2:    palette = 24'h7F7F00;
      3'd3:    palette = 24'h007F00;
      3'd4:    palette = 24'h00007F;
      3'd5:    palette = 24'h250041;
      3'd6:    palette = 24'h774177;
      default: palette = 24'h7F0000;
    endcase
  endfunction

  function automatic logic [2:0] next_index(input logic [2:0] idx, input logic rev);
    if (rev) next_index = (idx == 3'd0) ? 3'd6 : idx - 3'd1;
    else     next_index = (idx == 3'd6) ? 3'd0 : idx + 3'd1;
  endfunction

  // The clamp keeps the add/subtract inside 0..255, so no overflow occurs.
  function automatic logic [7:0] fade_step(input logic [7:0] cur, input logic [7:0] tgt);
    if (tgt >= cur) fade_step = ((tgt - cur) <= STEP8) ? tgt : cur + STEP8;
    else            fade_step = ((cur - tgt) <= STEP8) ? tgt : cur - STEP8;
  endfunction

  state_t         state_q, state_d;
  logic [2:0]     idx_q, idx_d;
  logic [7:0]     duty_r_q, duty_r_d;
  logic [7:0]     duty_g_q, duty_g_d;
  logic [7:0]     duty_b_q, duty_b_d;
  logic [HCW-1:0] hold_cnt_q, hold_cnt_d;
  logic           wrap_q, wrap_d;
  logic           skip_q, skip_d;

  logic           skip_edge;
  logic [23:0]    target;
  logic [2:0]     adv_idx;
  logic [23:0]    adv_target;
  logic           adv_wraps;
  logic [7:0]     faded_r, faded_g, faded_b;

  // Next-state logic: skip beats step_tick, and a run drop always returns to IDLE.
  always_comb begin
    skip_d     = skip;
    skip_edge  = skip & ~skip_q;
    target     = palette(idx_q);
    adv_idx    = next_index(idx_q, dir);
    adv_target = palette(adv_idx);
    adv_wraps  = dir ? (idx_q == 3'd0) : (idx_q == 3'd6);
    faded_r    = fade_step(duty_r_q, target[23:16]);
    faded_g    = fade_step(duty_g_q, target[15:8]);
    faded_b    = fade_step(duty_b_q, target[7:0]);

    state_d    = state_q;
    idx_d      = idx_q;
    duty_r_d   = duty_r_q;
    duty_g_d   = duty_g_q;
    duty_b_d   = duty_b_q;
    hold_cnt_d = hold_cnt_q;
    wrap_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (skip_edge) begin
          idx_d    = adv_idx;
          wrap_d   = adv_wraps;
          duty_r_d = adv_target[23:16];
          duty_g_d = adv_target[15:8];
          duty_b_d = adv_target[7:0];
        end else if (run) begin
          hold_cnt_d = '0;
          state_d    = ({duty_r_q, duty_g_q, duty_b_q} == target) ? HOLD : FADE;
        end
      end
      HOLD, FADE: begin
        if (!run) begin
          state_d    = IDLE;
          hold_cnt_d = '0;
          if (skip_edge) begin
            idx_d    = adv_idx;
            wrap_d   = adv_wraps;
            duty_r_d = adv_target[23:16];
            duty_g_d = adv_target[15:8];
            duty_b_d = adv_target[7:0];
          end
        end else if (skip_edge) begin
          idx_d      = adv_idx;
          wrap_d     = adv_wraps;
          hold_cnt_d = '0;
          state_d    = FADE;
        end else if (step_tick) begin
          if (state_q == HOLD) begin
            if (hold_cnt_q == HOLD_LAST) begin
              idx_d      = adv_idx;
              wrap_d     = adv_wraps;
              hold_cnt_d = '0;
              state_d    = FADE;
            end else begin
              hold_cnt_d = hold_cnt_q + 1'b1;
            end
          end else begin
            duty_r_d = faded_r;
            duty_g_d = faded_g;
            duty_b_d = faded_b;
            if ({faded_r, faded_g, faded_b} == target) begin
              hold_cnt_d = '0;
              state_d    = HOLD;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset aborts any fade straight back to red at index 0.
  always_ff @(posedge clk) begin
    if (nrst) begin
      state_q    <= IDLE;
      idx_q      <= 3'd0;
      duty_r_q   <= 8'h7F;
      duty_g_q   <= 8'h00;
      duty_b_q   <= 8'h00;
      hold_cnt_q <= '0;
      wrap_q     <= 1'b0;
      skip_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      duty_r_q   <= duty_r_d;
      duty_g_q   <= duty_g_d;
      duty_b_q   <= duty_b_d;
      hold_cnt_q <= hold_cnt_d;
      wrap_q     <= wrap_d;
      skip_q     <= skip_d;
    end
  end

`ifdef RGB_SEQ_DIM_EN
  logic [7:0] dim_r_q, dim_g_q, dim_b_q;
  logic [2:0] dim_idx_q;
  logic       dim_busy_q, dim_wrap_q;

  // Extra output stage: dimmed duties plus status delayed to stay aligned.
  always_ff @(posedge clk) begin
    if (nrst) begin
      dim_r_q    <= 8'h7F;
      dim_g_q    <= 8'h00;
      dim_b_q    <= 8'h00;
      dim_idx_q  <= 3'd0;
      dim_busy_q <= 1'b0;
      dim_wrap_q <= 1'b0;
    end else begin
      dim_r_q    <= duty_r_q >> dim;
      dim_g_q    <= duty_g_q >> dim;
      dim_b_q    <= duty_b_q >> dim;
      dim_idx_q  <= idx_q;
      dim_busy_q <= (state_q == FADE);
      dim_wrap_q <= wrap_q;
    end
  end

  assign duty_r    = dim_r_q;
  assign duty_g    = dim_g_q;
  assign duty_b    = dim_b_q;
  assign color_idx = dim_idx_q;
  assign busy      = dim_busy_q;
  assign wrap      = dim_wrap_q;
`else
  assign duty_r    = duty_r_q;
  assign duty_g    = duty_g_q;
  assign duty_b    = duty_b_q;
  assign color_idx = idx_q;
  assign busy      = (state_q == FADE);
  assign wrap      = wrap_q;
`endif

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Testbench for rgb_fade_sequencer (default build, RGB_SEQ_DIM_EN undefined).
// A behavioural palette/fade model tracks the expected outputs every cycle;
// directed scenarios add fixed-value checks on top.
module tb_rgb_fade_sequencer;

  localparam int HOLD_TICKS = 3;
  localparam int STEP       = 16;

  logic       clk = 1'b0;
  logic       nrst = 1'b1;
  logic       step_tick = 1'b0;
  logic       run = 1'b0;
  logic       dir = 1'b0;
  logic       skip = 1'b0;
  logic [7:0] duty_r, duty_g, duty_b;
  logic [2:0] color_idx;
  logic       busy, wrap;

  int compareCount = 0;
  int failCount    = 0;

  // Reference model: 0 = resting/paused, 1 = holding, 2 = fading.
  int pal[7][3] = '{'{8'h7F, 8'h00, 8'h00}, '{8'h7F, 8'h52, 8'h00}, '{8'h7F, 8'h7F, 8'h00},
                    '{8'h00, 8'h7F, 8'h00}, '{8'h00, 8'h00, 8'h7F}, '{8'h25, 8'h00, 8'h41},
                    '{8'h77, 8'h41, 8'h77}};
  int mMode, mIdx, mHold;
  int mDuty[3];
  bit mWrap, mSkipPrev;

  rgb_fade_sequencer #(.HOLD_TICKS(HOLD_TICKS), .STEP(STEP)) dut (
    .clk(clk), .nrst(nrst), .step_tick(step_tick), .run(run), .dir(dir), .skip(skip),
    .duty_r(duty_r), .duty_g(duty_g), .duty_b(duty_b),
    .color_idx(color_idx), .busy(busy), .wrap(wrap)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    compareCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic modelAdvance(input bit d);
    if (d) begin
      mWrap = (mIdx == 0);
      mIdx  = (mIdx + 6) % 7;
    end else begin
      mWrap = (mIdx == 6);
      mIdx  = (mIdx + 1) % 7;
    end
  endtask

  task automatic modelSnap();
    for (int c = 0; c < 3; c++) mDuty[c] = pal[mIdx][c];
  endtask

  function automatic bit modelAtTarget();
    return mDuty[0] == pal[mIdx][0] && mDuty[1] == pal[mIdx][1] && mDuty[2] == pal[mIdx][2];
  endfunction

  task automatic modelStep(input bit r, input bit d, input bit s, input bit t, input bit rst);
    bit edgeSeen;
    int diff;
    if (rst) begin
      mMode = 0; mIdx = 0; mHold = 0; mWrap = 0; mSkipPrev = 0;
      modelSnap();
      return;
    end
    edgeSeen  = s && !mSkipPrev;
    mSkipPrev = s;
    mWrap     = 0;
    if (mMode == 0) begin
      if (edgeSeen) begin
        modelAdvance(d);
        modelSnap();
      end else if (r) begin
        mHold = 0;
        mMode = modelAtTarget() ? 1 : 2;
      end
    end else if (!r) begin
      mMode = 0;
      mHold = 0;
      if (edgeSeen) begin
        modelAdvance(d);
        modelSnap();
      end
    end else if (edgeSeen) begin
      modelAdvance(d);
      mHold = 0;
      mMode = 2;
    end else if (t) begin
      if (mMode == 1) begin
        if (mHold == HOLD_TICKS - 1) begin
          modelAdvance(d);
          mHold = 0;
          mMode = 2;
        end else begin
          mHold++;
        end
      end else begin
        for (int c = 0; c < 3; c++) begin
          diff = pal[mIdx][c] - mDuty[c];
          if (diff <= STEP && diff >= -STEP) mDuty[c] = pal[mIdx][c];
          else if (diff > 0)                 mDuty[c] = mDuty[c] + STEP;
          else                               mDuty[c] = mDuty[c] - STEP;
        end
        if (modelAtTarget()) begin
          mHold = 0;
          mMode = 1;
        end
      end
    end
  endtask

  task automatic checkModel();
    checkOutput("model_r",    int'(duty_r),    mDuty[0]);
    checkOutput("model_g",    int'(duty_g),    mDuty[1]);
    checkOutput("model_b",    int'(duty_b),    mDuty[2]);
    checkOutput("model_idx",  int'(color_idx), mIdx);
    checkOutput("model_busy", int'(busy),      int'(mMode == 2));
    checkOutput("model_wrap", int'(wrap),      int'(mWrap));
  endtask

  // One clock cycle: drive inputs, step the model at the edge, check #1 later.
  task automatic applyStimulus(input bit r, input bit d, input bit s, input bit t);
    run = r; dir = d; skip = s; step_tick = t;
    @(posedge clk);
    modelStep(r, d, s, t, nrst);
    #1;
    checkModel();
  endtask

  task automatic tickOnce(input bit r, input bit d);
    applyStimulus(r, d, 1'b0, 1'b1);
    applyStimulus(r, d, 1'b0, 1'b0);
  endtask

  task automatic doReset();
    nrst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    nrst = 1'b0;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_r"},    int'(duty_r),    8'h7F);
    checkOutput({tag, "_g"},    int'(duty_g),    8'h00);
    checkOutput({tag, "_b"},    int'(duty_b),    8'h00);
    checkOutput({tag, "_idx"},  int'(color_idx), 0);
    checkOutput({tag, "_busy"}, int'(busy),      0);
    checkOutput({tag, "_wrap"}, int'(wrap),      0);
  endtask

  int gSeq[6] = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h52};
  int gResume[4] = '{8'h30, 8'h40, 8'h50, 8'h52};

  initial begin
    // Reset held for two cycles.
    nrst = 1'b1;
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    nrst = 1'b0;
    checkResetValues("reset");

    // Forward automatic sequencing from red toward orange.
    applyStimulus(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) tickOnce(1, 0);
    checkOutput("fwd_idx", int'(color_idx), 1);
    checkOutput("fwd_busy", int'(busy), 1);
    for (int i = 0; i < 6; i++) begin
      tickOnce(1, 0);
      checkOutput($sformatf("fwd_g%0d", i), int'(duty_g), gSeq[i]);
      checkOutput($sformatf("fwd_r%0d", i), int'(duty_r), 8'h7F);
    end
    checkOutput("fwd_done_busy", int'(busy), 0);

    // Reverse skip from reset wraps 0 -> 6 and snaps to the last colour.
    doReset();
    applyStimulus(0, 1, 1, 0);
    checkOutput("rev_idx", int'(color_idx), 6);
    checkOutput("rev_r", int'(duty_r), 8'h77);
    checkOutput("rev_g", int'(duty_g), 8'h41);
    checkOutput("rev_b", int'(duty_b), 8'h77);
    checkOutput("rev_wrap", int'(wrap), 1);
    applyStimulus(0, 1, 0, 0);
    checkOutput("rev_wrap_end", int'(wrap), 0);

    // Pause mid-fade, then resume.
    doReset();
    applyStimulus(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) tickOnce(1, 0);
    checkOutput("pause_g", int'(duty_g), 8'h20);
    applyStimulus(0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      tickOnce(0, 0);
      checkOutput("paused_g", int'(duty_g), 8'h20);
    end
    applyStimulus(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      tickOnce(1, 0);
      checkOutput($sformatf("resume_g%0d", i), int'(duty_g), gResume[i]);
    end

    // Skip and step_tick together while holding at index 2.
    doReset();
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("snap2_g", int'(duty_g), 8'h7F);
    applyStimulus(1, 0, 0, 0);
    tickOnce(1, 0);
    applyStimulus(1, 0, 1, 1);
    checkOutput("both_idx", int'(color_idx), 3);
    checkOutput("both_busy", int'(busy), 1);
    applyStimulus(1, 0, 0, 0);
    for (int i = 0; i < 20 && busy; i++) tickOnce(1, 0);
    checkOutput("both_done", int'(busy), 0);
    checkOutput("both_idx2", int'(color_idx), 3);
    checkOutput("both_r", int'(duty_r), 8'h00);
    checkOutput("both_g", int'(duty_g), 8'h7F);
    checkOutput("both_b", int'(duty_b), 8'h00);

    // Reset asserted during a fade aborts to the reset values.
    doReset();
    applyStimulus(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) tickOnce(1, 0);
    checkOutput("abort_pre_busy", int'(busy), 1);
    nrst = 1'b1;
    applyStimulus(1, 0, 0, 0);
    nrst = 1'b0;
    checkResetValues("abort");

    // Randomised traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      nrst = ($urandom_range(0, 299) == 0);
      applyStimulus($urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1);
    end
    nrst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
